// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: widths, S-box tables, key-schedule and S-box layer helpers.
package present_pkg;

    localparam int KEY_W      = 80;
    localparam int BLK_W      = 64;
    localparam int ROUNDS_STD = 31;
    localparam int CNT_W      = 5;

    // Tables packed so that entry x sits at bits [4x+3:4x].
    localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] SBOX_INV = 64'hA970364BD21C8FE5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_WHITEN = 2'd2,
        ST_ROUND  = 2'd3
    } fsm_state_t;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] sbox4_inv(input logic [3:0] x);
        return SBOX_INV[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [BLK_W-1:0] sbox_layer_inv(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = sbox4_inv(x[4*n +: 4]);
        end
        return r;
    endfunction

    function automatic logic [KEY_W-1:0] fwd_key_update(input logic [KEY_W-1:0] k,
                                                        input logic [CNT_W-1:0] i);
        logic [KEY_W-1:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox4(r[79:76]);
        r[19:15]   = r[19:15] ^ i;
        return r;
    endfunction

    // Undoes fwd_key_update step by step in reverse order.
    function automatic logic [KEY_W-1:0] inv_key_update(input logic [KEY_W-1:0] k,
                                                        input logic [CNT_W-1:0] i);
        logic [KEY_W-1:0] r;
        r          = k;
        r[19:15]   = r[19:15] ^ i;
        r[79:76]   = sbox4_inv(r[79:76]);
        r          = {r[60:0], r[79:61]};
        return r;
    endfunction

endpackage

// File: rtl/present80_decrypt_if.sv
// Request/response bundle of the PRESENT-80 decryptor.
interface present80_decrypt_if;
    import present_pkg::*;

    logic              start;
    logic [KEY_W-1:0]  key;
    logic [BLK_W-1:0]  data_in;
    logic              busy;
    logic              done;
    logic [BLK_W-1:0]  data_out;

    modport master (
        output start, key, data_in,
        input  busy, done, data_out
    );

    modport slave (
        input  start, key, data_in,
        output busy, done, data_out
    );

endinterface

// File: rtl/present_inv_player.sv
// Inverse PRESENT bit permutation: out[j] = in[16*j mod 63], bit 63 fixed.
module present_inv_player
    import present_pkg::*;
(
    input  logic [BLK_W-1:0] din,
    output logic [BLK_W-1:0] dout
);

    for (genvar j = 0; j < 63; j++) begin : g_bit
        assign dout[j] = din[(32'd16 * j) % 32'd63];
    end

    assign dout[63] = din[63];

endmodule

// File: rtl/present80_decrypt.sv
// Iterative PRESENT-80 decryptor: forward key expansion to K32, whitening, then ROUNDS inverse rounds.
module present80_decrypt
    import present_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_STD
) (
    input  logic                clk,
    input  logic                rst,
    present80_decrypt_if.slave  bus
);

    localparam logic [CNT_W-1:0] ROUNDS_C = CNT_W'(ROUNDS);

    fsm_state_t         state_r;
    fsm_state_t         state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [BLK_W-1:0]   data_r;
    logic [KEY_W-1:0]   key_r;
    logic               busy_r;
    logic               done_r;
    logic [BLK_W-1:0]   dout_r;

    logic               load_s;
    logic               kexp_s;
    logic               whiten_s;
    logic               round_en_s;
    logic               last_s;
    logic [BLK_W-1:0]   invp_s;
    logic [BLK_W-1:0]   round_s;

    present_inv_player u_inv_player (
        .din  (data_r),
        .dout (invp_s)
    );

    assign round_s = sbox_layer_inv(invp_s) ^ key_r[79:16];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx_s = ST_KEYEXP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_KEYEXP: begin
                if (cnt_r == ROUNDS_C) begin
                    state_nx_s = ST_WHITEN;
                end else begin
                    state_nx_s = ST_KEYEXP;
                end
            end
            ST_WHITEN: begin
                state_nx_s = ST_ROUND;
            end
            ST_ROUND: begin
                if (cnt_r == 5'd1) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_ROUND;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: datapath step enables
    always_comb begin
        load_s     = 1'b0;
        kexp_s     = 1'b0;
        whiten_s   = 1'b0;
        round_en_s = 1'b0;
        last_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s = bus.start;
            end
            ST_KEYEXP: begin
                kexp_s = 1'b1;
            end
            ST_WHITEN: begin
                whiten_s = 1'b1;
            end
            ST_ROUND: begin
                round_en_s = 1'b1;
                last_s     = (cnt_r == 5'd1);
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Cipher state, key schedule register and round counter
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= '0;
            key_r  <= '0;
            cnt_r  <= '0;
        end else if (load_s) begin
            data_r <= bus.data_in;
            key_r  <= bus.key;
            cnt_r  <= 5'd1;
        end else if (kexp_s) begin
            key_r  <= fwd_key_update(key_r, cnt_r);
            cnt_r  <= cnt_r + 5'd1;
        end else if (whiten_s) begin
            // key_r holds K32 here; step back to K31 for the first inverse round.
            data_r <= data_r ^ key_r[79:16];
            key_r  <= inv_key_update(key_r, ROUNDS_C);
            cnt_r  <= ROUNDS_C;
        end else if (round_en_s) begin
            data_r <= round_s;
            if (cnt_r > 5'd1) begin
                key_r <= inv_key_update(key_r, cnt_r - 5'd1);
            end
            cnt_r  <= cnt_r - 5'd1;
        end
    end

    // Registered handshake outputs and plaintext
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dout_r <= '0;
        end else begin
            done_r <= last_s;
            if (load_s) begin
                busy_r <= 1'b1;
            end else if (last_s) begin
                busy_r <= 1'b0;
            end
            if (last_s) begin
                dout_r <= round_s;
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.data_out = dout_r;

endmodule

// File: tb/tb_present80_decrypt.sv
// Self-checking bench for present80_decrypt: transaction-level PRESENT model plus directed vectors.
module tb_present80_decrypt;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    present80_decrypt_if bus();

    present80_decrypt #(.ROUNDS(31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [3:0] sb  [0:15] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [3:0] sbi [0:15];

    localparam logic [79:0] K0 = 80'h0;
    localparam logic [79:0] K1 = 80'hFFFFFFFFFFFFFFFFFFFF;
    localparam logic [63:0] ZERO = 64'h0;
    localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;

    // Standard key schedule: round keys K1..K32
    function automatic void key_sched(input logic [79:0] k, output logic [63:0] rk [1:32]);
        logic [79:0] kk;
        kk = k;
        for (int r = 1; r <= 32; r++) begin
            rk[r] = kk[79:16];
            kk = (kk << 61) | (kk >> 19);
            kk[79:76] = sb[kk[79:76]];
            kk[19:15] = kk[19:15] ^ 5'(r);
        end
    endfunction

    function automatic logic [63:0] ref_encrypt(input logic [79:0] k, input logic [63:0] p);
        logic [63:0] rk [1:32];
        logic [63:0] s, t;
        key_sched(k, rk);
        s = p;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ rk[r];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = sb[s[4*n +: 4]];
            for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (i * 16) % 63] = t[i];
        end
        return s ^ rk[32];
    endfunction

    function automatic logic [63:0] ref_decrypt(input logic [79:0] k, input logic [63:0] c);
        logic [63:0] rk [1:32];
        logic [63:0] s, t;
        key_sched(k, rk);
        s = c ^ rk[32];
        for (int r = 31; r >= 1; r--) begin
            for (int i = 0; i < 64; i++) t[i] = s[(i == 63) ? 63 : (i * 16) % 63];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sbi[t[4*n +: 4]];
            s = s ^ rk[r];
        end
        return s;
    endfunction

    // Transaction model: accept when idle, result appears 63 edges later
    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [63:0] m_out = '0, m_pend = '0;
    int          m_rem = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_out <= '0; m_rem <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (bus.start) begin
                    m_busy <= 1'b1;
                    m_rem  <= 63;
                    m_pend <= ref_decrypt(bus.key, bus.data_in);
                end
            end else if (m_rem == 1) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_out <= m_pend; m_rem <= 0;
            end else begin
                m_rem <= m_rem - 1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (bus.busy !== m_busy || bus.done !== m_done || bus.data_out !== m_out) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t busy=%b exp %b done=%b exp %b data_out=%h exp %h",
                         $time, bus.busy, m_busy, bus.done, m_done, bus.data_out, m_out);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic go(input logic [79:0] k, input logic [63:0] d);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.key = k; bus.data_in = d;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.done && n < 200);
    endtask

    task automatic run(input string name, input logic [79:0] k, input logic [63:0] d,
                       input logic [63:0] exp);
        int n;
        go(k, d);
        wait_done(n);
        check({name, "_latency"}, 64'(n), 64'd63);
        check({name, "_data"}, bus.data_out, exp);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (bus.done) cnt++;
        end
    endtask

    initial begin
        int n, m, dn;
        for (int v = 0; v < 16; v++) sbi[sb[v]] = 4'(v);
        bus.start = 1'b0; bus.key = '0; bus.data_in = '0;

        // Pin the model on published PRESENT-80 vectors
        check("model_enc_k0_p0", ref_encrypt(K0, ZERO), 64'h5579C1387B228445);
        check("model_enc_k1_p1", ref_encrypt(K1, ONES), 64'h3333DCD3213210D2);
        check("model_dec_v1", ref_decrypt(K0, 64'h5579C1387B228445), ZERO);
        check("model_dec_v2", ref_decrypt(K1, 64'hE72C46C0F5945049), ZERO);
        check("model_dec_v3", ref_decrypt(K0, 64'hA112FFC72F68417B), ONES);
        check("model_dec_v4", ref_decrypt(K1, 64'h3333DCD3213210D2), ONES);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_data", bus.data_out, ZERO);

        run("v1", K0, 64'h5579C1387B228445, ZERO);
        run("v2", K1, 64'hE72C46C0F5945049, ZERO);
        run("v3", K0, 64'hA112FFC72F68417B, ONES);

        // v4 with a stray start at edge 10 that must be ignored
        go(K1, 64'h3333DCD3213210D2);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 9) begin
                bus.start = 1'b1; bus.key = K0; bus.data_in = ZERO;
            end
            if (n == 10) begin
                bus.start = 1'b0;
                check("v4_busy_at_e10", 64'(bus.busy), 64'd1);
            end
        end while (!bus.done && n < 200);
        check("v4_latency", 64'(n), 64'd63);
        check("v4_data", bus.data_out, ONES);
        count_dones(70, dn);
        check("v4_single_done", 64'(dn), 64'd0);

        // Reset at edge 40 aborts the run
        go(K0, 64'h5579C1387B228445);
        for (int c = 1; c < 40; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_data", bus.data_out, ZERO);
        rst = 1'b0;
        count_dones(80, dn);
        check("abort_no_done", 64'(dn), 64'd0);

        // Back-to-back: start held through the done cycle
        @(posedge clk); #1;
        bus.start = 1'b1; bus.key = K0; bus.data_in = 64'hA112FFC72F68417B;
        @(posedge clk); #1;
        bus.key = K1; bus.data_in = 64'hE72C46C0F5945049;
        wait_done(n);
        check("b2b_first_latency", 64'(n), 64'd63);
        check("b2b_first_data", bus.data_out, ONES);
        m = 0;
        do begin
            @(posedge clk); #1;
            m++;
            if (m == 1) bus.start = 1'b0;
            if (m == 32) check("b2b_hold_data", bus.data_out, ONES);
        end while (!bus.done && m < 200);
        check("b2b_gap", 64'(m), 64'd64);
        check("b2b_second_data", bus.data_out, ZERO);
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
